gray_code_counter: RTL
======================

GRAY_CODE_COUNTER -- requirements
Module: gray_code_counter

Interface
REQ-001 Parameter: WIDTH, default 4, counter and code width in bits (legal 2..16).
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: en  input  1  count enable; requests production of Gray values.
REQ-005 Port: up_dn  input  1  direction: 1 = increment, 0 = decrement.
REQ-006 Port: load  input  1  synchronous load strobe.
REQ-007 Port: load_val  input  WIDTH  binary value to load.
REQ-008 Port: out_ready  input  1  downstream (Gray-to-binary stage) accepts gray_out.
REQ-009 Port: out_valid  output  1  gray_out holds a valid code.
REQ-010 Port: gray_out  output  WIDTH  registered Gray code of the internal count.
REQ-011 Port: wrap  output  1  one-cycle pulse on count roll-over.

Function
REQ-012 Internal binary count register cnt[WIDTH-1:0] SHALL hold the counter state.
REQ-013 gray_out SHALL be registered and always equal cnt ^ (cnt >> 1), updated on the same edge as cnt (no extra latency).
REQ-014 Transfer SHALL occur on an edge where out_valid=1 and out_ready=1.
REQ-015 On a transfer without load, cnt SHALL become cnt+1 (up_dn=1) or cnt-1 (up_dn=0), modulo 2^WIDTH.
REQ-016 out_valid SHALL go 1 on the edge after en is sampled 1 while out_valid=0 and load=0.
REQ-017 After a transfer, out_valid SHALL stay 1 if en=1, else go 0.
REQ-018 While out_valid=1 and out_ready=0, gray_out and out_valid SHALL hold unchanged regardless of en or up_dn (no retraction).
REQ-019 load=1 SHALL take priority over everything: cnt <= load_val, out_valid <= 0, wrap <= 0; any pending value is discarded, even if a transfer handshake occurs on the same edge.
REQ-020 wrap SHALL pulse 1 for exactly one cycle after a transfer taking cnt from 2^WIDTH-1 to 0 (up) or 0 to 2^WIDTH-1 (down); otherwise 0.
REQ-021 Successive gray_out values between loads SHALL differ in exactly one bit, including across wrap.
REQ-022 up_dn SHALL be sampled only on the transfer edge; changes at other times have no effect.

Reset
REQ-023 rst_n=0 SHALL immediately (asynchronously) force cnt=0, gray_out=0, out_valid=0, wrap=0.
REQ-024 Release of rst_n SHALL take effect at the next clk edge; first out_valid no earlier than one edge after release with en=1.
REQ-025 Reset asserted mid-count or mid-handshake SHALL discard all state; no partial transfer is recorded.

Structure
REQ-026 Shared package gray_pkg SHALL hold default WIDTH constant and a bin2gray function used by this block and its testbench.
REQ-027 One combinational sub-module bin_to_gray (WIDTH parameter) SHALL compute the next Gray value; counter, handshake and wrap logic stay in gray_code_counter.
REQ-028 Top-level integration SHALL allow gray_out to drive the Gray-to-binary converter directly.

Verification (WIDTH=4)
REQ-029 rst_n=0 asynchronously mid-cycle -> gray_out=0000, out_valid=0, wrap=0 without waiting for clk.
REQ-030 en=1, up_dn=1, out_ready=1 for 17 transfers -> gray_out 0000,0001,0011,0010,0110,0111,0101,0100,1100,...,1000,0000; wrap=1 only the cycle after 1000->0000.
REQ-031 out_valid=1, gray_out=0011, out_ready=0 for 3 cycles with en toggling -> gray_out stays 0011, out_valid stays 1; next ready edge -> 0010.
REQ-032 From reset, en=1, up_dn=0, out_ready=1 -> gray_out 0000 then 1000 (cnt=15), wrap pulses once.
REQ-033 load=1, load_val=4'd10 on same edge as a transfer -> gray_out=1111, out_valid=0 next cycle, wrap=0; with en=1, out_valid=1 one cycle later, next transfer up -> 1110.
REQ-034 Self-check: every transferred gray_out fed through a Gray-to-binary model equals expected binary count; Hamming distance 1 between consecutive transfers.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter: default width, handshake state
// encoding and the binary-to-Gray mapping used by the RTL and its bench.
package gray_pkg;

   localparam int GRAY_WIDTH   = 4;
   localparam int GRAY_MAX_W   = 16;

   // IDLE: no code offered downstream. VALID: gray_out is offered and held.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_VALID = 1'b1
   } state_t;

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary-to-Gray converter; the counter registers its output so
// gray_out tracks cnt on the same edge.
module bin_to_gray
   import gray_pkg::*;
#(
   parameter int WIDTH = GRAY_WIDTH
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   logic [GRAY_MAX_W-1:0] bin_ext;

   assign bin_ext = GRAY_MAX_W'(bin);
   assign gray    = WIDTH'(bin2gray(bin_ext));

endmodule

// File: rtl/gray_code_counter.sv
// Up/down binary counter that presents its Gray-coded value on a valid/ready
// output and advances only when that value is accepted downstream.
module gray_code_counter
   import gray_pkg::*;
#(
   parameter int WIDTH = GRAY_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] gray_out,
   output logic             wrap
);

   // Handshake: a transfer happens on any rising edge with out_valid=1 and
   // out_ready=1. Once raised, out_valid and gray_out hold until that transfer
   // (or a load/reset); the counter advances only on a transfer.
   state_t           state, state_nxt;
   logic [WIDTH-1:0] cnt, cnt_nxt, gray_nxt;
   logic             wrap_nxt;

   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      wrap_nxt  = 1'b0;
      if (load) begin
         // Load overrides any pending handshake, including one completing now.
         cnt_nxt   = load_val;
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (en) state_nxt = ST_VALID;
            end
            ST_VALID: begin
               if (out_ready) begin
                  if (up_dn) begin
                     cnt_nxt  = cnt + 1'b1;
                     wrap_nxt = (cnt == CNT_MAX);
                  end else begin
                     cnt_nxt  = cnt - 1'b1;
                     wrap_nxt = (cnt == '0);
                  end
                  state_nxt = en ? ST_VALID : ST_IDLE;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   bin_to_gray #(.WIDTH(WIDTH)) u_bin_to_gray (
      .bin  (cnt_nxt),
      .gray (gray_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         gray_out <= '0;
         wrap     <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         gray_out <= gray_nxt;
         wrap     <= wrap_nxt;
      end
   end

   assign out_valid = (state == ST_VALID);

endmodule
